// File: rtl/riscv_biu_arbiter.sv
// Round-robin BIU port arbiter with lock support and an in-order routing FIFO
// that steers ack/err/d_ack back to the master owning each outstanding transaction.
module riscv_biu_arbiter #(
  parameter int XLEN           = 32,
  parameter int PLEN           = XLEN,
  parameter int MASTERS        = 2,
  parameter int INFLIGHT_DEPTH = 2,
  localparam int CW            = $clog2(INFLIGHT_DEPTH + 1)
) (
  input  logic               rst_ni,
  input  logic               clk_i,

  input  logic [MASTERS-1:0] m_stb_i,
  output logic [MASTERS-1:0] m_stb_ack_o,
  input  logic [PLEN-1:0]    m_adri_i [MASTERS],
  input  logic [2:0]         m_size_i [MASTERS],
  input  logic [2:0]         m_type_i [MASTERS],
  input  logic [2:0]         m_prot_i [MASTERS],
  input  logic [MASTERS-1:0] m_lock_i,
  input  logic [MASTERS-1:0] m_we_i,
  input  logic [XLEN-1:0]    m_d_i    [MASTERS],
  output logic [MASTERS-1:0] m_d_ack_o,
  output logic [PLEN-1:0]    m_adro_o [MASTERS],
  output logic [XLEN-1:0]    m_q_o    [MASTERS],
  output logic [MASTERS-1:0] m_ack_o,
  output logic [MASTERS-1:0] m_err_o,

  output logic               biu_stb_o,
  output logic [PLEN-1:0]    biu_adri_o,
  output logic [2:0]         biu_size_o,
  output logic [2:0]         biu_type_o,
  output logic               biu_lock_o,
  output logic [2:0]         biu_prot_o,
  output logic               biu_we_o,
  output logic [XLEN-1:0]    biu_d_o,
  input  logic               biu_stb_ack_i,
  input  logic               biu_d_ack_i,
  input  logic [PLEN-1:0]    biu_adro_i,
  input  logic [XLEN-1:0]    biu_q_i,
  input  logic               biu_ack_i,
  input  logic               biu_err_i,

  output logic [CW-1:0]      inflight_cnt_o
);

  localparam int MW = $clog2(MASTERS);
  localparam int PW = (INFLIGHT_DEPTH > 1) ? $clog2(INFLIGHT_DEPTH) : 1;

  typedef struct packed {
    logic [MW-1:0] owner;
    logic          we;
    logic [3:0]    cnt;
  } entry_t;

  entry_t        fifo [INFLIGHT_DEPTH];
  entry_t        head;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [MW-1:0] last_grant, lock_owner, sel, rr_start;
  logic          lock_valid;
  logic          empty, full, block, accept, pop, dec, found;
  int unsigned   rr_idx;

  function automatic logic [3:0] burst_cnt(input logic [2:0] t);
    case (t[2:1])
      2'd0:    return 4'd0;
      2'd1:    return 4'd3;
      2'd2:    return 4'd7;
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(INFLIGHT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head  = fifo[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(INFLIGHT_DEPTH));

  // Round-robin search starts one past the last grant; an active lock overrides it.
  always_comb begin
    rr_start = (last_grant == MW'(MASTERS - 1)) ? '0 : last_grant + 1'b1;
    sel      = rr_start;
    found    = 1'b0;
    rr_idx   = 0;
    for (int unsigned i = 0; i < MASTERS; i++) begin
      rr_idx = (int'(rr_start) + i) % MASTERS;
      if (!found && m_stb_i[rr_idx]) begin
        sel   = MW'(rr_idx);
        found = 1'b1;
      end
    end
    if (lock_valid) sel = lock_owner;
  end

  // A write occupies the FIFO alone, so a write head means a write is in flight.
  assign block     = full | (m_we_i[sel] & ~empty) | (~empty & head.we);
  assign biu_stb_o = m_stb_i[sel] & ~block;
  assign accept    = biu_stb_o & biu_stb_ack_i;

  assign biu_adri_o = m_adri_i[sel];
  assign biu_size_o = m_size_i[sel];
  assign biu_type_o = m_type_i[sel];
  assign biu_lock_o = m_lock_i[sel];
  assign biu_prot_o = m_prot_i[sel];
  assign biu_we_o   = m_we_i[sel];
  assign biu_d_o    = biu_stb_o ? m_d_i[sel] : m_d_i[head.owner];

  assign pop = ~empty & (biu_err_i | (biu_ack_i & (head.cnt == '0)));
  assign dec = ~empty & biu_ack_i & ~biu_err_i & (head.cnt != '0);

  always_comb begin
    m_stb_ack_o      = '0;
    m_ack_o          = '0;
    m_err_o          = '0;
    m_d_ack_o        = '0;
    m_stb_ack_o[sel] = accept;
    if (!empty) begin
      m_ack_o[head.owner]   = biu_ack_i;
      m_err_o[head.owner]   = biu_err_i;
      m_d_ack_o[head.owner] = biu_d_ack_i;
    end
    for (int unsigned i = 0; i < MASTERS; i++) begin
      m_adro_o[i] = biu_adro_i;
      m_q_o[i]    = biu_q_i;
    end
  end

  assign inflight_cnt_o = count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      lock_valid <= 1'b0;
      lock_owner <= '0;
      last_grant <= MW'(MASTERS - 1);
      for (int unsigned i = 0; i < INFLIGHT_DEPTH; i++) fifo[i] <= '0;
    end else begin
      if (accept) begin
        fifo[wr_ptr] <= entry_t'{owner: sel, we: m_we_i[sel], cnt: burst_cnt(m_type_i[sel])};
        wr_ptr       <= ptr_inc(wr_ptr);
        last_grant   <= sel;
      end
      if (dec) fifo[rd_ptr].cnt <= head.cnt - 4'd1;
      if (pop) rd_ptr <= ptr_inc(rd_ptr);

      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (accept && m_lock_i[sel]) begin
        lock_valid <= 1'b1;
        lock_owner <= sel;
      end else if (lock_valid && !m_lock_i[lock_owner]) begin
        lock_valid <= 1'b0;
      end
    end
  end

endmodule
